// File: rtl/usb_fs_in_ep_buf_if.sv
// Client put/ack handshake and protocol-engine transmit signals of one IN endpoint buffer.
// master = client + engine side, slave = packet buffer.
interface usb_fs_in_ep_buf_if;
    logic       in_ep_req;
    logic       in_ep_grant;
    logic       in_ep_data_free;
    logic       in_ep_data_put;
    logic [7:0] in_ep_data;
    logic       in_ep_data_done;
    logic       in_ep_stall;
    logic       in_ep_acked;
    logic       setup_token;
    logic       in_xfr_start;
    logic       in_xfr_end;
    logic       in_data_ready;
    logic       in_stall;
    logic       tx_data_avail;
    logic       tx_data_get;
    logic [7:0] tx_data;
    logic       tx_data1;

    modport master (
        output in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
               setup_token, in_xfr_start, in_xfr_end, tx_data_get,
        input  in_ep_grant, in_ep_data_free, in_ep_acked, in_data_ready, in_stall,
               tx_data_avail, tx_data, tx_data1
    );

    modport slave (
        input  in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
               setup_token, in_xfr_start, in_xfr_end, tx_data_get,
        output in_ep_grant, in_ep_data_free, in_ep_acked, in_data_ready, in_stall,
               tx_data_avail, tx_data, tx_data1
    );
endinterface

// File: rtl/usb_fs_in_ep_buf.sv
// Full-speed IN endpoint packet buffer: fills from the client, hands one packet with its
// DATA0/DATA1 PID to the engine, replays on retry. Optional: USB_IN_EP_AUTO_ZLP_EN (ZLP after full packet).
//   state | meaning
//   FILL  | accepting client bytes
//   READY | complete packet waiting for an IN token
//   SEND  | engine reading the packet; may rewind on retry
module usb_fs_in_ep_buf #(
    parameter int MAX_PKT_SIZE = 32
) (
    input  logic              clk,
    input  logic              reset,
    usb_fs_in_ep_buf_if.slave bus
);
    localparam int AW = $clog2(MAX_PKT_SIZE);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL = PW'(MAX_PKT_SIZE);

    typedef enum logic [1:0] {FILL, READY, SEND} state_t;
    state_t state, state_next;

    logic [7:0]    mem [MAX_PKT_SIZE];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_next;
    logic          grant, toggle, acked;
    logic          free, accept, avail, zlp_now;
    logic          xfr_ack, rewind, advance;

    assign free    = (state == FILL) && (wr_ptr < FULL);
    assign accept  = grant && free && bus.in_ep_data_put;
    assign wr_next = wr_ptr + PW'(accept);
    assign avail   = (state == SEND) && (rd_ptr < wr_ptr);

`ifdef USB_IN_EP_AUTO_ZLP_EN
    logic zlp_pending, done_full;

    // A done that lands on a full packet owes the host a trailing zero-length packet.
    assign done_full = bus.in_ep_data_done && (wr_next == FULL);
    assign zlp_now   = zlp_pending || done_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zlp_pending <= 1'b0;
        end else if (bus.setup_token || xfr_ack) begin
            zlp_pending <= 1'b0;
        end else if (done_full) begin
            zlp_pending <= 1'b1;
        end
    end
`else
    assign zlp_now = 1'b0;
`endif

    always_comb begin
        state_next = state;
        xfr_ack    = 1'b0;
        rewind     = 1'b0;
        advance    = 1'b0;
        if (bus.setup_token) begin
            state_next = FILL;
        end else begin
            case (state)
                FILL: begin
                    if (bus.in_ep_data_done || wr_next == FULL) state_next = READY;
                end
                READY: begin
                    if (bus.in_xfr_start) begin
                        state_next = SEND;
                        rewind     = 1'b1;
                    end
                end
                SEND: begin
                    if (bus.in_xfr_end) begin
                        xfr_ack    = 1'b1;
                        state_next = zlp_now ? READY : FILL;
                    end else if (bus.in_xfr_start) begin
                        rewind = 1'b1;
                    end else if (bus.tx_data_get && avail) begin
                        advance = 1'b1;
                    end
                end
                default: state_next = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FILL;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            toggle <= 1'b0;
            acked  <= 1'b0;
            grant  <= 1'b0;
        end else begin
            grant <= bus.in_ep_req;
            acked <= xfr_ack;
            if (bus.setup_token) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                toggle <= 1'b1;
            end else begin
                if (accept) wr_ptr <= wr_next;
                if (xfr_ack) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    toggle <= ~toggle;
                end else if (rewind) begin
                    rd_ptr <= '0;
                end else if (advance) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= bus.in_ep_data;
    end

    assign bus.in_ep_grant     = grant;
    assign bus.in_ep_data_free = free;
    assign bus.in_ep_acked     = acked;
    assign bus.in_data_ready   = (state == READY);
    assign bus.in_stall        = bus.in_ep_stall;
    assign bus.tx_data_avail   = avail;
    assign bus.tx_data         = (state == SEND) ? mem[rd_ptr[AW-1:0]] : 8'h00;
    assign bus.tx_data1        = toggle;
endmodule

// File: tb/tb_usb_fs_in_ep_buf.sv
// Scoreboard bench for usb_fs_in_ep_buf: random client puts and engine gets checked against
// a packet-level model (byte stream split into MAX-sized packets, alternating PID).
`timescale 1ns/1ps
module tb_usb_fs_in_ep_buf;
    localparam int MAX = 32;
`ifdef USB_IN_EP_AUTO_ZLP_EN
    localparam bit ZLP = 1'b1;
`else
    localparam bit ZLP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    usb_fs_in_ep_buf_if bus();

    usb_fs_in_ep_buf #(.MAX_PKT_SIZE(MAX)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    byte unsigned sent_q[$];
    byte unsigned cur_pkt[$];
    int plan_q[$];
    int rd_idx = 0;
    int acked_cnt = 0;
    bit exp_toggle = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packets the model expects from an n-byte transfer closed by done.
    function automatic void plan(input int n);
        plan_q.delete();
        for (int k = 0; k < n / MAX; k++) plan_q.push_back(MAX);
        if (n % MAX != 0) plan_q.push_back(n % MAX);
        else if (n == 0 || ZLP) plan_q.push_back(0);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (bus.in_ep_acked) acked_cnt++;
            if (bus.tx_data_get && bus.tx_data_avail) begin
                if (rd_idx < cur_pkt.size()) check("tx_data", int'(bus.tx_data), int'(cur_pkt[rd_idx]));
                else check("tx_overrun", rd_idx, cur_pkt.size());
                rd_idx++;
            end
        end
    end

    task automatic client_send(input int n, input bit give_done);
        int i = 0;
        int budget = 0;
        bit with_last = ($urandom_range(0, 1) == 1);
        bus.in_ep_req = 1'b1;
        while (i < n && budget < 5000) begin
            if (bus.in_ep_grant && bus.in_ep_data_free && $urandom_range(0, 3) != 0) begin
                bus.in_ep_data_put = 1'b1;
                bus.in_ep_data = 8'($urandom);
                sent_q.push_back(bus.in_ep_data);
                i++;
                if (i == n && give_done && with_last) bus.in_ep_data_done = 1'b1;
            end
            step();
            bus.in_ep_data_put = 1'b0;
            bus.in_ep_data_done = 1'b0;
            bus.in_ep_data = 8'($urandom);
            budget++;
        end
        if (i < n) check("put_timeout", i, n);
        if (give_done && !(with_last && n > 0)) begin
            bus.in_ep_data_done = 1'b1;
            step();
            bus.in_ep_data_done = 1'b0;
        end
    endtask

    task automatic wait_ready(output bit ok);
        int waited = 0;
        while (!bus.in_data_ready && waited < 3000) begin
            step();
            waited++;
        end
        ok = bus.in_data_ready;
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    task automatic load_pkt(input int plen);
        cur_pkt.delete();
        for (int k = 0; k < plen && sent_q.size() > 0; k++) cur_pkt.push_back(sent_q.pop_front());
        rd_idx = 0;
    endtask

    task automatic serve(input int plen, input int retry_at);
        int got = 0;
        int waited = 0;
        int a0;
        bit retried = 1'b0;
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        check("tx_data1_ready", bus.tx_data1, exp_toggle);
        check("free_in_ready", bus.in_ep_data_free, 0);
        load_pkt(plen);
        bus.in_xfr_start = 1'b1;
        step();
        bus.in_xfr_start = 1'b0;
        check("avail_start", bus.tx_data_avail, int'(plen > 0));
        check("free_in_send", bus.in_ep_data_free, 0);
        while (got < plen && waited < 3000) begin
            if ($urandom_range(0, 3) != 0) begin
                bus.tx_data_get = 1'b1;
                if (bus.tx_data_avail) got++;
            end
            step();
            bus.tx_data_get = 1'b0;
            waited++;
            if (retry_at > 0 && !retried && got == retry_at) begin
                retried = 1'b1;
                got = 0;
                bus.in_xfr_start = 1'b1;
                rd_idx = 0;
                step();
                bus.in_xfr_start = 1'b0;
                check("tx_data_replay", int'(bus.tx_data), int'(cur_pkt[0]));
                check("tx_data1_retry", bus.tx_data1, exp_toggle);
            end
        end
        check("bytes_read", rd_idx, plen);
        check("avail_end", bus.tx_data_avail, 0);
        bus.tx_data_get = 1'b1;
        step();
        bus.tx_data_get = 1'b0;
        check("avail_stray_get", bus.tx_data_avail, 0);
        a0 = acked_cnt;
        bus.in_xfr_end = 1'b1;
        step();
        bus.in_xfr_end = 1'b0;
        check("acked_pulse", bus.in_ep_acked, 1);
        exp_toggle = ~exp_toggle;
        check("tx_data1_after", bus.tx_data1, exp_toggle);
        step();
        check("acked_low", bus.in_ep_acked, 0);
        check("acked_single", acked_cnt - a0, 1);
    endtask

    task automatic reset_out_checks();
        check("rst_grant", bus.in_ep_grant, 0);
        check("rst_ready", bus.in_data_ready, 0);
        check("rst_avail", bus.tx_data_avail, 0);
        check("rst_tx_data", int'(bus.tx_data), 0);
        check("rst_tx_data1", bus.tx_data1, 0);
        check("rst_acked", bus.in_ep_acked, 0);
        check("rst_stall", bus.in_stall, 0);
    endtask

    initial begin
        bit ok;
        int a0;
        int w;
        bus.in_ep_req = 1'b0;
        bus.in_ep_data_put = 1'b0;
        bus.in_ep_data = 8'h00;
        bus.in_ep_data_done = 1'b0;
        bus.in_ep_stall = 1'b0;
        bus.setup_token = 1'b0;
        bus.in_xfr_start = 1'b0;
        bus.in_xfr_end = 1'b0;
        bus.tx_data_get = 1'b0;
        #2;
        reset_out_checks();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // puts without a grant are dropped
        bus.in_ep_data_put = 1'b1;
        bus.in_ep_data = 8'hEE;
        step();
        step();
        bus.in_ep_data_put = 1'b0;
        bus.in_ep_req = 1'b1;
        check("grant_delay", bus.in_ep_grant, 0);
        step();
        check("grant", bus.in_ep_grant, 1);

        fork
            client_send(18, 1'b1);
            serve(18, 0);
        join

        bus.setup_token = 1'b1;
        step();
        bus.setup_token = 1'b0;
        exp_toggle = 1'b1;
        check("setup_toggle", bus.tx_data1, 1);

        plan(67);
        fork
            client_send(67, 1'b1);
            for (int k = 0; k < plan_q.size(); k++) serve(plan_q[k], 0);
        join

        fork
            client_send(12, 1'b1);
            serve(12, 5);
        join

        fork
            client_send(0, 1'b1);
            serve(0, 0);
        join

        plan(32);
        fork
            client_send(32, 1'b1);
            begin
                serve(plan_q[0], 0);
                check("ready_after_full", bus.in_data_ready, int'(ZLP));
                for (int k = 1; k < plan_q.size(); k++) serve(plan_q[k], 0);
            end
        join

        client_send(4, 1'b0);
        bus.in_xfr_start = 1'b1;
        step();
        bus.in_xfr_start = 1'b0;
        check("start_in_fill_ready", bus.in_data_ready, 0);
        check("start_in_fill_avail", bus.tx_data_avail, 0);
        check("start_in_fill_free", bus.in_ep_data_free, 1);
        bus.in_ep_data_done = 1'b1;
        step();
        bus.in_ep_data_done = 1'b0;
        serve(4, 0);

        bus.in_ep_stall = 1'b1;
        #1;
        check("stall_on", bus.in_stall, 1);
        step();
        check("stall_state", bus.in_data_ready, 0);
        check("stall_free", bus.in_ep_data_free, 1);
        bus.in_ep_stall = 1'b0;
        #1;
        check("stall_off", bus.in_stall, 0);

        // setup during SEND after 10 of 20 bytes
        client_send(20, 1'b1);
        wait_ready(ok);
        load_pkt(20);
        bus.in_xfr_start = 1'b1;
        step();
        bus.in_xfr_start = 1'b0;
        w = 0;
        while (rd_idx < 10 && w < 200) begin
            bus.tx_data_get = 1'b1;
            step();
            w++;
        end
        bus.tx_data_get = 1'b0;
        check("read10", rd_idx, 10);
        a0 = acked_cnt;
        bus.setup_token = 1'b1;
        step();
        bus.setup_token = 1'b0;
        exp_toggle = 1'b1;
        check("setup_ready", bus.in_data_ready, 0);
        check("setup_avail", bus.tx_data_avail, 0);
        check("setup_tx_data1", bus.tx_data1, 1);
        check("setup_free", bus.in_ep_data_free, 1);
        repeat (3) step();
        check("setup_no_ack", acked_cnt - a0, 0);
        sent_q.delete();

        // asynchronous reset while partly filled
        client_send(5, 1'b0);
        reset = 1'b0;
        #1;
        reset_out_checks();
        step();
        reset = 1'b1;
        exp_toggle = 1'b0;
        sent_q.delete();
        step();
        fork
            client_send(3, 1'b1);
            serve(3, 0);
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
